inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the RV32I core, directly upstream of the controller/ALU/register-file datapath in `cpu_top`. Owns the architectural fetch PC and issues word reads to a synchronous instruction BRAM with one-cycle read latency. Delivers `{pc, inst}` pairs downstream over a valid/ready handshake, buffering up to two words so full throughput survives downstream stalls. Accepts redirects (taken branch, JAL/JALR) from the execute logic.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `IMEM_AW`, 14, instruction-memory word-address width (64 KiB).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `redirect_valid` input 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` input 32: target byte address.
- `imem_en` output 1: read strobe to the instruction BRAM.
- `imem_addr` output IMEM_AW: word address, equal to `fetch_pc[IMEM_AW+1:2]`.
- `imem_rdata` input 32: read data, valid the cycle after `imem_en`.
- `inst_valid` output 1: `inst`/`pc` hold a valid instruction.
- `inst_ready` input 1: downstream accepts this cycle.
- `inst` output 32: instruction word.
- `pc` output 32: byte address of `inst`.
- `fetch_err` output 1: sticky misaligned-redirect error.

## Operation
- States: RUN, HALT. Reset puts the block in RUN with `fetch_pc=RESET_PC`, buffer empty, nothing in flight, and all outputs 0.
- Buffer: output slot (drives `inst`/`pc`) plus one skid slot. Occupancy `occ = out_valid + skid_valid + inflight`.
- Issue: in RUN, with no redirect this cycle and `occ_next < 2` after accounting for this cycle's handshake, assert `imem_en`, tag the request with `fetch_pc`, set `inflight`, and advance `fetch_pc += 4`. The add wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 0.
- Return: in-flight data goes into the output slot if that slot is empty or being consumed this cycle; otherwise it goes into the skid slot. The skid slot refills the output slot before newer data.
- Handshake: a transfer happens when `inst_valid && inst_ready`. While `inst_valid` is high and `inst_ready` is low, `inst`/`pc` hold stable.
- Redirect (`redirect_valid=1`):
  - A transfer in the same cycle completes.
  - Otherwise the output and skid slots are cleared.
  - Any in-flight response is marked stale and discarded on return.
  - No issue this cycle; `fetch_pc <= redirect_pc`.
- Misaligned redirect (`redirect_pc[1:0]!=0`): flush as for a normal redirect, then set `fetch_err`, enter HALT, and issue nothing further. Only `rst` leaves HALT.
- Redirect has priority over issue. `rst` has priority over everything and clears a flush, halt or stale request in progress.
- Addresses beyond 2^(IMEM_AW+2) alias; no bounds error is raised.

## Timing
- First fetch: `imem_en=1` in the first cycle with `rst=0` (cycle 0), data at cycle 1, `inst_valid=1` with `pc=RESET_PC` at cycle 2.
- Steady state with `inst_ready=1`: one instruction per cycle, `pc` incrementing by 4.
- Redirect at cycle r: issue at r+1 and `inst_valid` with `pc=redirect_pc` at r+3. Cycles r+1 and r+2 have `inst_valid=0`.
- Stall release: after any stall, the next two instructions are delivered back-to-back with no bubble.
- Registered outputs: `inst_valid`, `inst`, `pc`, `fetch_err`.
- Combinational outputs: `imem_en`, `imem_addr`, derived from state and the current-cycle handshake or redirect.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN=32`.
  - `RESET_PC` default.
  - Fetch state enum {RUN, HALT}.
  - `fetch_pkt_t` struct {pc, inst}.
- Sub-module `fetch_skid_buf`: 2-entry valid/ready buffer holding `fetch_pkt_t`, with flush input.
- The top-level FSM, PC register and stale-tag logic stay in `inst_fetch`.

## Test plan
- Reset release with `inst_ready=1`, BRAM word n = n: `inst_valid` rises at cycle 2; outputs `pc`=0,4,8 with `inst`=0,1,2 on consecutive cycles.
- Hold `inst_ready=0` for 5 cycles from cycle 3:
  - `imem_en` drops once occupancy reaches 2.
  - `pc`=4 holds stable.
  - After release, `pc`=8 and `pc`=12 appear back-to-back; no word is lost or duplicated.
- `redirect_valid=1`, `redirect_pc`=32'h100 while a request is in flight and the skid slot is full:
  - Stale data is dropped.
  - Next valid output is `pc`=32'h100 exactly 3 cycles later, followed by 32'h104.
- Redirect in the same cycle as an accepted transfer: the accepted `pc` is counted once and the following output is the redirect target.
- `redirect_pc`=32'h102:
  - `fetch_err=1` from the next cycle.
  - `imem_en` stays 0 and `inst_valid` stays 0 thereafter.
  - `rst` for one cycle clears the error and fetch restarts at 0.
- Redirect to 32'hFFFF_FFF8 with `RESET_PC` unchanged: fetch `pc` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000; `imem_addr` aliases accordingly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: word width, reset vector, fetch FSM states
// and the {pc, inst} packet passed from fetch to decode.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int IMEM_AW_DEFAULT = 14;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry valid/ready buffer for fetch packets: an output slot that drives
// downstream plus one skid slot, both cleared by flush.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  input  logic       out_ready,
  output logic       out_valid,
  output fetch_pkt_t out_pkt,
  output logic       skid_valid
);

  logic       out_valid_r;
  fetch_pkt_t out_pkt_r;
  logic       skid_valid_r;
  fetch_pkt_t skid_pkt_r;

  logic       out_valid_s;
  fetch_pkt_t out_pkt_s;
  logic       skid_valid_s;
  fetch_pkt_t skid_pkt_s;
  logic       xfer_s;

  assign xfer_s = out_valid_r & out_ready;

  // Next-state slot logic; the skid entry always refills the output slot first.
  always_comb begin
    out_valid_s  = out_valid_r;
    out_pkt_s    = out_pkt_r;
    skid_valid_s = skid_valid_r;
    skid_pkt_s   = skid_pkt_r;
    if (flush) begin
      out_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!out_valid_r || xfer_s) begin
      if (skid_valid_r) begin
        out_valid_s  = 1'b1;
        out_pkt_s    = skid_pkt_r;
        skid_valid_s = in_valid;
        skid_pkt_s   = in_valid ? in_pkt : skid_pkt_r;
      end else begin
        out_valid_s  = in_valid;
        out_pkt_s    = in_valid ? in_pkt : out_pkt_r;
        skid_valid_s = 1'b0;
      end
    end else if (in_valid) begin
      skid_valid_s = 1'b1;
      skid_pkt_s   = in_pkt;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_pkt_r    <= '0;
      skid_valid_r <= 1'b0;
      skid_pkt_r   <= '0;
    end else begin
      out_valid_r  <= out_valid_s;
      out_pkt_r    <= out_pkt_s;
      skid_valid_r <= skid_valid_s;
      skid_pkt_r   <= skid_pkt_s;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_pkt    = out_pkt_r;
  assign skid_valid = skid_valid_r;

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues one-cycle-latency
// BRAM reads and hands {pc, inst} downstream through a two-entry buffer.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              IMEM_AW  = IMEM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [XLEN-1:0]    inst,
  output logic [XLEN-1:0]    pc,
  output logic               fetch_err
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            inflight_r;
  logic            fetch_err_r;

  logic            out_valid_s;
  logic            skid_valid_s;
  fetch_pkt_t      out_pkt_s;
  fetch_pkt_t      ret_pkt_s;
  logic            ret_valid_s;
  logic            stale_s;
  logic            xfer_s;
  logic            issue_s;
  logic [1:0]      occ_s;
  logic [1:0]      occ_next_s;

  assign xfer_s     = out_valid_s & inst_ready;
  assign occ_s      = {1'b0, out_valid_s} + {1'b0, skid_valid_s} + {1'b0, inflight_r};
  assign occ_next_s = occ_s - {1'b0, xfer_s};

  // A redirect arriving while a read is outstanding makes that read stale; with
  // one-cycle latency its data is on imem_rdata this very cycle and is dropped.
  assign stale_s     = inflight_r & redirect_valid;
  assign ret_valid_s = inflight_r & ~stale_s;
  assign ret_pkt_s   = '{pc: req_pc_r, inst: imem_rdata};

  assign issue_s = ~rst & (state_r == RUN) & ~redirect_valid & (occ_next_s < 2'd2);

  assign imem_en   = issue_s;
  assign imem_addr = fetch_pc_r[IMEM_AW+1:2];

  // FSM, fetch PC, request tag and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      fetch_pc_r  <= RESET_PC;
      req_pc_r    <= '0;
      inflight_r  <= 1'b0;
      fetch_err_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        req_pc_r <= fetch_pc_r;
      end
      if (redirect_valid && (state_r == RUN)) begin
        fetch_pc_r <= redirect_pc;
        if (is_misaligned(redirect_pc)) begin
          state_r     <= HALT;
          fetch_err_r <= 1'b1;
        end
      end else if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
    end
  end

  fetch_skid_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .in_valid   (ret_valid_s),
    .in_pkt     (ret_pkt_s),
    .out_ready  (inst_ready),
    .out_valid  (out_valid_s),
    .out_pkt    (out_pkt_s),
    .skid_valid (skid_valid_s)
  );

  assign inst_valid = out_valid_s;
  assign inst       = out_pkt_s.inst;
  assign pc         = out_pkt_s.pc;
  assign fetch_err  = fetch_err_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed timing checks plus a randomized run, all
// delivered instructions checked by a scoreboard of expected PCs.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_err;

  int checks;
  int failures;
  int xfer_cnt;

  logic [31:0] mem [0:16383];
  logic [31:0] exp_q [$];
  logic        err_m;
  logic        halted_m;
  logic        hold_m;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  localparam int WIN = 3000;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < WIN; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Reference model: the stream is consecutive words from the last reset or
  // aligned redirect; a misaligned redirect empties it and halts fetch.
  always @(posedge clk) begin
    if (rst) begin
      refill(32'h0000_0000);
      err_m    = 1'b0;
      halted_m = 1'b0;
    end else if (redirect_valid && !halted_m) begin
      if (redirect_pc[1:0] != 2'b00) begin
        exp_q.delete();
        halted_m = 1'b1;
        err_m    = 1'b1;
      end else begin
        refill(redirect_pc);
      end
    end
  end

  // Monitor: compares every transfer and the hold/halt rules.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      hold_m = 1'b0;
    end else begin
      chk("fetch_err", {31'd0, fetch_err}, {31'd0, err_m});
      if (halted_m) begin
        chk("halt_imem_en", {31'd0, imem_en}, 32'd0);
        chk("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
      end
      if (hold_m) begin
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_pc", pc, hold_pc);
        chk("hold_inst", inst, hold_inst);
      end
      if (inst_valid && inst_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer_pc", pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pc", pc, e);
          chk("xfer_inst", inst, mem[e[15:2]]);
        end
      end
      hold_m    = inst_valid && !inst_ready && !redirect_valid;
      hold_pc   = pc;
      hold_inst = inst;
    end
  end

  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = r;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic sample_vp(input string name, input logic v, input logic [31:0] p, input logic [31:0] i);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, inst_valid}, {31'd0, v});
    if (v) begin
      chk({name, "_pc"}, pc, p);
      chk({name, "_inst"}, inst, i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int halt_cnt;
    logic [31:0] rnd;
    logic rv;
    logic rdy;
    checks = 0; failures = 0; xfer_cnt = 0;
    hold_m = 1'b0; err_m = 1'b0; halted_m = 1'b0;
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    for (int n = 0; n < 16384; n++) mem[n] = n;

    // Reset state
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_imem_en", {31'd0, imem_en}, 32'd0);

    // First fetch latency
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("c0_imem_en", {31'd0, imem_en}, 32'd1);
    chk("c0_imem_addr", {18'd0, imem_addr}, 32'd0);
    chk("c0_valid", {31'd0, inst_valid}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("c1", 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("c2", 1'b1, 32'd0, 32'd0);

    // Stall for 5 cycles from cycle 3
    for (int k = 3; k < 8; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      sample_vp("stall", 1'b1, 32'd4, 32'd1);
      chk("stall_imem_en", {31'd0, imem_en}, 32'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rel0", 1'b1, 32'd4, 32'd1);
    chk("rel_imem_en", {31'd0, imem_en}, 32'd1);
    chk("rel_imem_addr", {18'd0, imem_addr}, 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rel1", 1'b1, 32'd8, 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rel2", 1'b1, 32'd12, 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rel3", 1'b1, 32'd16, 32'd4);

    // Redirect while the buffer is full and stalled
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h100);
    sample_vp("rd_r", 1'b1, 32'd20, 32'd5);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rd_r1", 1'b0, 32'd0, 32'd0);
    chk("rd_r1_imem_addr", {18'd0, imem_addr}, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rd_r2", 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rd_r3", 1'b1, 32'h100, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rd_r4", 1'b1, 32'h104, 32'h41);

    // Redirect in the same cycle as an accepted transfer
    cyc(1'b0, 1'b1, 1'b1, 32'h200);
    sample_vp("rx_r", 1'b1, 32'h108, 32'h42);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rx_r1", 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rx_r2", 1'b0, 32'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rx_r3", 1'b1, 32'h200, 32'h80);

    // Misaligned redirect halts until reset
    cyc(1'b0, 1'b1, 1'b1, 32'h102);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      chk("mis_fetch_err", {31'd0, fetch_err}, 32'd1);
      chk("mis_imem_en", {31'd0, imem_en}, 32'd0);
      chk("mis_valid", {31'd0, inst_valid}, 32'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("rr_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rr_imem_en", {31'd0, imem_en}, 32'd1);
    chk("rr_imem_addr", {18'd0, imem_addr}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("rr_c2", 1'b1, 32'd0, 32'd0);

    // Address wrap and aliasing
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("wr_imem_en", {31'd0, imem_en}, 32'd1);
    chk("wr_addr0", {18'd0, imem_addr}, 32'h3FFE);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("wr_addr1", {18'd0, imem_addr}, 32'h3FFF);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("wr_addr2", {18'd0, imem_addr}, 32'h0);
    chk("wr_pc0", pc, 32'hFFFF_FFF8);
    chk("wr_inst0", inst, 32'h3FFE);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("wr1", 1'b1, 32'hFFFF_FFFC, 32'h3FFF);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    sample_vp("wr2", 1'b1, 32'h0, 32'h0);

    // Randomized run against the scoreboard
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int n = 0; n < 16384; n++) mem[n] = $urandom;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    xfer_cnt = 0;
    halt_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      rdy = ($urandom_range(0, 99) < 70);
      rv  = ($urandom_range(0, 99) < 3);
      rnd = $urandom;
      if ($urandom_range(0, 19) != 0) rnd[1:0] = 2'b00;
      else if (rnd[1:0] == 2'b00) rnd[1:0] = 2'b10;
      halt_cnt = halted_m ? halt_cnt + 1 : 0;
      if (halt_cnt > 6) begin
        cyc(1'b1, rdy, 1'b0, 32'd0);
        halt_cnt = 0;
      end else begin
        cyc(1'b0, rdy, rv, rnd);
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("progress", {31'd0, (xfer_cnt > 300)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
